// File: rtl/simon_ti_pkg.sv
// Shared types and Din field layout for the Simon-128/128 threshold-core share loader.
package simon_ti_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadRnd,
        StLoadData,
        StStart,
        StWait,
        StUnload
    } state_e;

    localparam logic [9:0] SH0_LSB = 10'd0;
    localparam logic [9:0] SH1_LSB = 10'd256;
    localparam logic [9:0] RND_LSB = 10'd512;

    localparam int unsigned N_RND_WORDS  = 16;
    localparam int unsigned N_DATA_WORDS = 8;
    localparam int unsigned N_OUT_WORDS  = 4;

    // LSB of 32-bit word idx inside a 256-bit field starting at base; word 0 is the MSW.
    function automatic logic [9:0] word_lsb(input logic [9:0] base, input logic [2:0] idx);
        logic [2:0] rev;
        rev = 3'd7 - idx;
        return base + {2'b00, rev, 5'd0};
    endfunction

endpackage

// File: rtl/simon_share_loader.sv
// Front-end for the two-share Simon-128/128 core: gathers masks and data, masks each data word
// on arrival, launches the core, then serialises the 128-bit result as four 32-bit words.
module simon_share_loader
    import simon_ti_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RSTn,

    input  logic [WORD_W-1:0] rnd_data,
    input  logic              rnd_valid,
    output logic              rnd_ready,

    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,

    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,

    output logic [767:0]      Din,
    output logic              Drdy,
    output logic              EN,
    input  logic              BSY,
    input  logic [127:0]      Dout,
    input  logic              Dvld,

    output logic              busy
);

    state_e        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [767:0]  din_q, din_d;
    logic [127:0]  dout_q, dout_d;
    logic          en_q;

    logic [9:0]    rnd_lsb;
    logic [9:0]    sh0_lsb;
    logic [9:0]    sh1_lsb;
    logic [6:0]    out_lsb;

    always_comb begin
        // Mask words 0-7 land in share1, words 8-15 in the core refresh field.
        rnd_lsb = word_lsb(wcnt_q[3] ? RND_LSB : SH1_LSB, wcnt_q[2:0]);
        sh0_lsb = word_lsb(SH0_LSB, wcnt_q[2:0]);
        sh1_lsb = word_lsb(SH1_LSB, wcnt_q[2:0]);
        out_lsb = {~wcnt_q[1:0], 5'd0};
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        din_d     = din_q;
        dout_d    = dout_q;
        rnd_ready = 1'b0;
        in_ready  = 1'b0;
        Drdy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;

        unique case (state_q)
            StIdle: begin
                if (rnd_valid) begin
                    state_d = StLoadRnd;
                end
            end

            StLoadRnd: begin
                rnd_ready = 1'b1;
                if (rnd_valid) begin
                    din_d[rnd_lsb +: WORD_W] = rnd_data;
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == 4'(N_RND_WORDS - 1)) begin
                        state_d = StLoadData;
                    end
                end
            end

            StLoadData: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Mask before the register so the plain word is never stored.
                    din_d[sh0_lsb +: WORD_W] = in_data ^ din_q[sh1_lsb +: WORD_W];
                    if (wcnt_q == 4'(N_DATA_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = StStart;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end

            StStart: begin
                if (!BSY) begin
                    Drdy    = 1'b1;
                    state_d = StWait;
                end
            end

            StWait: begin
                if (Dvld) begin
                    dout_d  = Dout;
                    din_d   = '0;
                    state_d = StUnload;
                end
            end

            StUnload: begin
                out_valid = 1'b1;
                out_data  = dout_q[out_lsb +: WORD_W];
                if (out_ready) begin
                    if (wcnt_q == 4'(N_OUT_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = StIdle;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            en_q    <= 1'b1;
        end
    end

    assign Din  = din_q;
    assign EN   = en_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_simon_share_loader.sv
// Scoreboard bench for simon_share_loader: the bench plays host, TRNG, core and sink.
module tb_simon_share_loader;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic [31:0]   rnd_data = '0;
    logic          rnd_valid = 1'b0;
    logic          rnd_ready;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [767:0]  Din;
    logic          Drdy;
    logic          EN;
    logic          BSY = 1'b0;
    logic [127:0]  Dout = '0;
    logic          Dvld = 1'b0;
    logic          busy;

    simon_share_loader #(.WORD_W(32)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Din       (Din),
        .Drdy      (Drdy),
        .EN        (EN),
        .BSY       (BSY),
        .Dout      (Dout),
        .Dvld      (Dvld),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [767:0] din_exp_q[$];
    logic [31:0]  word_exp_q[$];
    logic [31:0]  rnd_w[16];
    logic [31:0]  dat_w[8];
    bit           stall_out = 1'b0;
    bit           spur_mode = 1'b0;

    task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Sink: out_ready changes just after the rising edge so monitors see it stable.
    initial forever begin
        @(posedge CLK);
        #1;
        out_ready = stall_out ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Core-start monitor: every Drdy must match the next expected shared input.
    initial forever begin
        @(negedge CLK);
        if (RSTn && Drdy) begin
            if (din_exp_q.size() == 0) chk("drdy_unexpected", 768'(Drdy), 768'd0);
            else chk("din_at_drdy", Din, din_exp_q.pop_front());
        end
    end

    // Output monitor: words in order, held while stalled.
    initial begin
        bit held;
        held = 1'b0;
        forever begin
            @(negedge CLK);
            if (held) chk("out_valid_held", 768'(out_valid), 768'd1);
            held = 1'b0;
            if (RSTn && out_valid) begin
                if (word_exp_q.size() == 0) begin
                    chk("out_unexpected", 768'(out_valid), 768'd0);
                end else if (out_ready) begin
                    chk("out_word", 768'(out_data), 768'(word_exp_q.pop_front()));
                end else begin
                    chk("out_word_stalled", 768'(out_data), 768'(word_exp_q[0]));
                    held = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one word on a stream and return at the falling edge after it was taken.
    task automatic push_word(input bit is_rnd, input logic [31:0] w, input bit stall);
        int n;
        if (stall) begin
            if (is_rnd) rnd_valid = 1'b0;
            else in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        if (is_rnd) begin
            rnd_data  = w;
            rnd_valid = 1'b1;
        end else begin
            in_data  = w;
            in_valid = 1'b1;
        end
        n = 0;
        while (!(is_rnd ? rnd_ready : in_ready)) begin
            @(negedge CLK);
            n++;
            if (n > 100) begin
                $display("FAIL stream_ready_timeout: ready never rose, required 1");
                $fatal(1, "timeout");
            end
        end
        if (is_rnd && spur_mode) chk("in_ready_low_in_load_rnd", 768'(in_ready), 768'd0);
        @(posedge CLK);
        @(negedge CLK);
        if (is_rnd) rnd_valid = 1'b0;
        else in_valid = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_din", Din, 768'd0);
        chk("rst_busy", 768'(busy), 768'd0);
        chk("rst_en", 768'(EN), 768'd0);
        chk("rst_drdy", 768'(Drdy), 768'd0);
        chk("rst_out_valid", 768'(out_valid), 768'd0);
        chk("rst_out_data", 768'(out_data), 768'd0);
        chk("rst_rnd_ready", 768'(rnd_ready), 768'd0);
        chk("rst_in_ready", 768'(in_ready), 768'd0);
    endtask

    task automatic release_reset();
        rnd_valid = 1'b0;
        in_valid  = 1'b0;
        RSTn      = 1'b1;
        @(negedge CLK);
        chk("en_after_reset", 768'(EN), 768'd1);
    endtask

    // One full operation; abort_at >= 0 asserts reset before that data word.
    task automatic run_txn(input bit stall, input bit bsy_hold, input bit spur, input int abort_at);
        logic [255:0] m, r, d;
        logic [767:0] exp;
        logic [127:0] ct;
        int n;
        for (int i = 0; i < 8; i++) begin
            m[255-32*i -: 32] = rnd_w[i];
            r[255-32*i -: 32] = rnd_w[8+i];
            d[255-32*i -: 32] = dat_w[i];
        end
        exp = {r, m, d ^ m};
        spur_mode = spur;
        if (spur) begin
            in_data  = 32'hdeadbeef;
            in_valid = 1'b1;
        end
        if (bsy_hold) BSY = 1'b1;
        for (int i = 0; i < 16; i++) push_word(1'b1, rnd_w[i], stall);
        spur_mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == abort_at) begin
                RSTn     = 1'b0;
                in_valid = 1'b1;
                rnd_valid = 1'b1;
                BSY      = 1'b0;
                #1;
                reset_checks();
                repeat (2) @(negedge CLK);
                chk("din_held_in_reset", Din, 768'd0);
                release_reset();
                return;
            end
            if (k == 7) din_exp_q.push_back(exp);
            if (spur && k == 2) begin
                Dvld = 1'b1;
                Dout = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            push_word(1'b0, dat_w[k], stall && !spur);
            Dvld = 1'b0;
        end
        if (bsy_hold) begin
            repeat (20) begin
                chk("no_drdy_while_bsy", 768'(Drdy), 768'd0);
                chk("din_stable_bsy", Din, exp);
                @(negedge CLK);
            end
            @(posedge CLK);
            #1;
            BSY = 1'b0;
            @(negedge CLK);
        end
        chk("drdy_latency", 768'(Drdy), 768'd1);
        @(negedge CLK);
        chk("drdy_one_cycle", 768'(Drdy), 768'd0);
        repeat ($urandom_range(0, 4)) begin
            chk("din_stable_wait", Din, exp);
            @(negedge CLK);
        end
        chk("din_stable_wait", Din, exp);
        ct   = {$urandom(), $urandom(), $urandom(), $urandom()};
        Dout = ct;
        Dvld = 1'b1;
        for (int i = 0; i < 4; i++) word_exp_q.push_back(ct[127-32*i -: 32]);
        @(negedge CLK);
        Dvld = 1'b0;
        Dout = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("out_valid_latency", 768'(out_valid), 768'd1);
        chk("din_cleared", Din, 768'd0);
        n = 0;
        while (busy) begin
            @(negedge CLK);
            n++;
            if (n > 200) begin
                $display("FAIL unload_timeout: busy still 1, required 0");
                $fatal(1, "timeout");
            end
        end
        chk("out_words_drained", 768'(word_exp_q.size()), 768'd0);
    endtask

    initial begin
        logic [255:0] pk;
        pk = {128'h63736564_20737265_6c6c6576_61727420, 128'h0f0e0d0c_0b0a0908_07060504_03020100};
        #12;
        reset_checks();
        @(negedge CLK);
        release_reset();

        for (int i = 0; i < 16; i++) rnd_w[i] = 32'h0;
        for (int i = 0; i < 8; i++) dat_w[i] = pk[255-32*i -: 32];
        run_txn(1'b0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 16; i++) rnd_w[i] = 32'ha5a5a5a5;
        run_txn(1'b0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 16; i++) rnd_w[i] = $urandom();
        run_txn(1'b0, 1'b1, 1'b0, -1);

        for (int i = 0; i < 16; i++) rnd_w[i] = $urandom();
        run_txn(1'b0, 1'b0, 1'b1, -1);

        run_txn(1'b1, 1'b0, 1'b0, 5);
        stall_out = 1'b1;
        for (int i = 0; i < 8; i++) dat_w[i] = $urandom();
        run_txn(1'b1, 1'b0, 1'b0, -1);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) rnd_w[i] = $urandom();
            for (int i = 0; i < 8; i++) dat_w[i] = $urandom();
            run_txn(1'b1, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        stall_out = 1'b0;
        repeat (3) @(negedge CLK);
        chk("din_queue_empty", 768'(din_exp_q.size()), 768'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simon_share_loader.md
# simon_share_loader

Front-end stage feeding the two-share threshold Simon-128/128 core (`TI_Simon_TopModule`). It gathers randomness and plaintext/key words over 32-bit valid/ready streams and masks each data word on arrival, so the unmasked value is never registered. It then assembles the 768-bit shared `Din` word and issues the single-cycle `Drdy` start strobe. Finally it captures the 128-bit `Dout` result on `Dvld` and streams it back out as four 32-bit words.

## Interface
- `WORD_W`, 32: stream word width; fixed at 32, other values unsupported.
- `CLK`  in  1  single clock; all logic rising-edge.
- `RSTn`  in  1  asynchronous active-low reset.
- `rnd_data`  in  32  randomness word from TRNG/PRNG.
- `rnd_valid`  in  1  randomness word available.
- `rnd_ready`  out  1  loader accepts randomness (LOAD_RND only).
- `in_data`  in  32  plaintext/key word from host.
- `in_valid`  in  1  host word available.
- `in_ready`  out  1  loader accepts host word (LOAD_DATA only).
- `out_data`  out  32  ciphertext word.
- `out_valid`  out  1  ciphertext word valid.
- `out_ready`  in  1  sink accepts ciphertext word.
- `Din`  out  768  shared core input.
- `Drdy`  out  1  one-cycle start strobe to core.
- `EN`  out  1  core enable.
- `BSY`  in  1  core busy.
- `Dout`  in  128  core ciphertext.
- `Dvld`  in  1  core result valid.
- `busy`  out  1  loader not in IDLE.

## Operation
- Din layout:
  - `Din[255:0]` = share0 = {pt ^ m_pt, key ^ m_key}; plaintext in [255:128].
  - `Din[511:256]` = share1 = mask m = {m_pt, m_key}.
  - `Din[767:512]` = refresh randomness r for the core.
- States: IDLE, LOAD_RND, LOAD_DATA, START, WAIT, UNLOAD.
- IDLE -> LOAD_RND when `rnd_valid`; the word is accepted in LOAD_RND, not in IDLE.
- LOAD_RND: accept 16 words, using a 4-bit word counter `wcnt`.
  - Words 0-7 fill `Din[511:256]` MSB-first: word 0 -> [511:480].
  - Words 8-15 fill `Din[767:512]` MSB-first.
  - After word 15: -> LOAD_DATA, `wcnt` = 0.
- LOAD_DATA: accept 8 words.
  - Word k is written to `Din[255-32k -: 32]` as `in_data ^ Din[511-32k -: 32]`.
  - Words 0-3 are plaintext, most significant first; words 4-7 are key, most significant first.
  - After word 7: -> START.
- START:
  - If `BSY`=0, assert `Drdy` for exactly one cycle, then -> WAIT.
  - If `BSY`=1, stay in START with `Drdy`=0.
- WAIT: on `Dvld`=1, register `Dout`, zero all 768 `Din` bits, -> UNLOAD.
- UNLOAD: present four words, `Dout[127:96]` first. Advance on `out_valid & out_ready`. After the 4th transfer -> IDLE.
- `EN`: registered, 0 in reset, 1 from the first clock edge after reset release.
- `busy` = (state != IDLE).

## Timing
- Reset values: all outputs 0, including `Din`, `out_data`, `Drdy`, `EN`, `busy`. State = IDLE, `wcnt` = 0.
- Transfers occur only on `valid & ready` at a rising edge. `rnd_ready` and `in_ready` are combinational from state only, never from the valid inputs.
- `Din` is stable from the `Drdy` cycle until `Dvld` is seen. `Drdy` is never asserted outside START.
- Latency:
  - Last data word accepted -> `Drdy` high: next cycle, if `BSY`=0.
  - `Dvld` -> `out_valid`: 1 cycle.
- `out_data`/`out_valid` are held while `out_ready`=0.
- Simultaneous `rnd_valid` and `in_valid`: only the stream for the current state is consumed; the other stream stalls.
- `Dvld` outside WAIT is ignored.
- `RSTn` low mid-operation: immediate asynchronous clear of all registers, including a partially masked `Din`. No stream word is accepted during reset.

## Structure
- Package `simon_ti_pkg`:
  - state enum;
  - field offsets SH0_LSB=0, SH1_LSB=256, RND_LSB=512;
  - N_RND_WORDS=16, N_DATA_WORDS=8, N_OUT_WORDS=4.
- Single module. Masking is one XOR per word and needs no sub-module. Out-of-module reuse of the UNLOAD serializer is optional as `simon_word_serializer`.

## Test plan
- All-zero randomness; pt 63736564_20737265_6c6c6576_61727420; key 0f0e0d0c_…_03020100 -> `Din[255:0]` = 6373…7420_0f0e…0100, `Din[767:256]` = 0, single `Drdy` pulse. With the real core, output words = 49681b1e, 1e54fe3f, 65aa832a, f84e0bbc.
- Randomness words all a5a5a5a5, same pt/key -> `Din[511:256]` all a5 bytes, `Din[255:0]` = pt/key ^ a5a5…, and share0 ^ share1 equals pt||key. Ciphertext matches the previous test.
- Hold `BSY`=1 for 20 cycles after the last data word -> no `Drdy` while `BSY`=1; `Drdy` one cycle after `BSY` falls; `Din` unchanged throughout.
- Random stalls on `rnd_valid`, `in_valid`, `out_ready` (probability 50%) -> same `Din` and output words as the stall-free runs; no word dropped or duplicated.
- Assert `RSTn`=0 after 5 data words -> all outputs 0 within the reset cycle, state IDLE. A fresh complete load afterwards produces the correct ciphertext.
- `in_valid` held high during LOAD_RND and `Dvld` pulsed during LOAD_DATA -> `in_ready`=0 in LOAD_RND, the spurious `Dvld` is ignored, and operation is unaffected.
